// File: rtl/cpu_common.sv
// Shared fetch-side types: word/address types, icache FSM states and line bundle.
// ICACHE_INVALIDATE_EN adds the SWEEP state used by the whole-cache invalidate.
package cpu_common;

    typedef logic [29:0] memaddr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        RESP_HOLD
`ifdef ICACHE_INVALIDATE_EN
        ,
        SWEEP
`endif
    } icache_state_t;

    typedef struct packed {
        memaddr_t tag;
        word_t    data;
    } icache_line_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped icache storage: valid flops plus tag/data array.
// Combinational read/hit, synchronous fill, per-index clear, reset-clear of valids.
module icache_array
    import cpu_common::*;
#(
    parameter int LINES = 64,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  memaddr_t         rd_addr_i,
    output logic             rd_hit_o,
    output word_t            rd_data_o,
    input  logic             wr_en_i,
    input  memaddr_t         wr_addr_i,
    input  word_t            wr_data_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i
);

    logic [LINES-1:0] valid_q;
    icache_line_t     lines_q [LINES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    memaddr_t         rd_tag;
    icache_line_t     rd_line;

    assign rd_idx    = rd_addr_i[IDX_W-1:0];
    assign wr_idx    = wr_addr_i[IDX_W-1:0];
    assign rd_tag    = rd_addr_i >> IDX_W;
    assign rd_line   = lines_q[rd_idx];
    assign rd_hit_o  = valid_q[rd_idx] && (rd_line.tag == rd_tag);
    assign rd_data_o = rd_line.data;

    // Valid bits: cleared on reset, set on fill, cleared one index at a time on sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            if (wr_en_i) valid_q[wr_idx] <= 1'b1;
            if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
        end
    end

    // Tag and data written on fill; contents are don't-care until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) lines_q[wr_idx] <= '{tag: wr_addr_i >> IDX_W, data: wr_data_i};
    end

endmodule

// File: rtl/icache_responder.sv
// Responder side of the fetch icache: 1-cycle hits, blocking single-word misses, flush.
// ICACHE_INVALIDATE_EN adds inv_i/inv_done_o and a LINES-cycle valid sweep.
module icache_responder
    import cpu_common::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        icache_flush_i,
    input  logic [29:0] icache_req_addr_i,
    input  logic        icache_req_valid_i,
    output logic        icache_req_ready_o,
    output logic [29:0] icache_resp_addr_o,
    output logic [31:0] icache_resp_data_o,
    output logic        icache_resp_valid_o,
    input  logic        icache_resp_ready_i,
    output logic [29:0] mem_req_addr_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    input  logic [31:0] mem_resp_data_i,
    input  logic        mem_resp_valid_i
`ifdef ICACHE_INVALIDATE_EN
    ,
    input  logic        inv_i,
    output logic        inv_done_o
`endif
);

    localparam int IDX_W = $clog2(LINES);

    icache_state_t    state_q, state_d;
    memaddr_t         miss_addr_q, resp_addr_q, load_addr;
    word_t            hold_data_q, resp_data_q, load_data, hit_data;
    logic             resp_valid_q, discard_q;
    logic             slot_free, req_ready, accept, hit;
    logic             load, fill_en, hold_en, disc_set, disc_clr;
    logic             inv_go, clr_en;
    logic [IDX_W-1:0] clr_idx;

    icache_array #(.LINES(LINES)) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_addr_i (icache_req_addr_i),
        .rd_hit_o  (hit),
        .rd_data_o (hit_data),
        .wr_en_i   (fill_en),
        .wr_addr_i (miss_addr_q),
        .wr_data_i (mem_resp_data_i),
        .clr_en_i  (clr_en),
        .clr_idx_i (clr_idx)
    );

`ifdef ICACHE_INVALIDATE_EN
    logic             inv_pend_q, inv_done_q;
    logic [IDX_W-1:0] sweep_idx_q;

    assign inv_go     = inv_i || inv_pend_q;
    assign clr_en     = (state_q == SWEEP);
    assign clr_idx    = sweep_idx_q;
    assign inv_done_o = inv_done_q;

    // Invalidates arriving outside IDLE wait here; sweep pointer and done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inv_pend_q  <= 1'b0;
            inv_done_q  <= 1'b0;
            sweep_idx_q <= '0;
        end else begin
            if (state_q == IDLE && inv_go) inv_pend_q <= 1'b0;
            else if (inv_i) inv_pend_q <= 1'b1;
            if (state_q == SWEEP) sweep_idx_q <= sweep_idx_q + IDX_W'(1);
            inv_done_q <= (state_q == SWEEP) && (sweep_idx_q == IDX_W'(LINES - 1));
        end
    end
`else
    assign inv_go  = 1'b0;
    assign clr_en  = 1'b0;
    assign clr_idx = '0;
`endif

    assign slot_free           = !resp_valid_q || icache_resp_ready_i;
    assign icache_req_ready_o  = req_ready;
    assign icache_resp_addr_o  = resp_addr_q;
    assign icache_resp_data_o  = resp_data_q;
    assign icache_resp_valid_o = resp_valid_q;
    assign mem_req_addr_o      = miss_addr_q;

    // Next-state, handshake outputs and datapath strobes.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        accept          = 1'b0;
        mem_req_valid_o = 1'b0;
        load            = 1'b0;
        load_addr       = miss_addr_q;
        load_data       = hold_data_q;
        fill_en         = 1'b0;
        hold_en         = 1'b0;
        disc_set        = 1'b0;
        disc_clr        = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = slot_free && !rst_i && !inv_go;
                accept    = icache_req_valid_i && req_ready;
                if (inv_go) begin
`ifdef ICACHE_INVALIDATE_EN
                    state_d = SWEEP;
`endif
                end else if (accept && hit) begin
                    load      = 1'b1;
                    load_addr = icache_req_addr_i;
                    load_data = hit_data;
                end else if (accept) begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                disc_set        = icache_flush_i;
                if (mem_req_ready_i) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_resp_valid_i) begin
                    fill_en  = 1'b1;
                    disc_clr = 1'b1;
                    if (discard_q || icache_flush_i) begin
                        state_d = IDLE;
                    end else if (slot_free) begin
                        load      = 1'b1;
                        load_data = mem_resp_data_i;
                        state_d   = IDLE;
                    end else begin
                        hold_en = 1'b1;
                        state_d = RESP_HOLD;
                    end
                end else begin
                    disc_set = icache_flush_i;
                end
            end
            RESP_HOLD: begin
                if (icache_flush_i) begin
                    state_d = IDLE;
                end else if (slot_free) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef ICACHE_INVALIDATE_EN
            SWEEP: begin
                if (sweep_idx_q == IDX_W'(LINES - 1)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Response slot occupancy (a load beats a same-cycle flush) and miss discard flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            if (load) resp_valid_q <= 1'b1;
            else if (icache_flush_i || icache_resp_ready_i) resp_valid_q <= 1'b0;
            if (disc_set) discard_q <= 1'b1;
            else if (disc_clr) discard_q <= 1'b0;
        end
    end

    // Response payload, miss address and parked fill word.
    always_ff @(posedge clk_i) begin
        if (load) begin
            resp_addr_q <= load_addr;
            resp_data_q <= load_data;
        end
        if (accept && !hit) miss_addr_q <= icache_req_addr_i;
        if (hold_en) hold_data_q <= mem_resp_data_i;
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: vector table, directed corners, random vs model.
// Define ICACHE_INVALIDATE_EN to also exercise the invalidate sweep.
`timescale 1ns/1ps
module tb_icache_responder;
    import cpu_common::*;

    localparam int LINES = 64;

    logic     clk = 1'b0;
    logic     rst_i;
    logic     flush;
    memaddr_t req_addr;
    logic     req_valid;
    logic     req_ready;
    memaddr_t resp_addr;
    word_t    resp_data;
    logic     resp_valid;
    logic     resp_ready;
    memaddr_t mem_req_addr;
    logic     mem_req_valid;
    logic     mem_req_ready;
    word_t    mem_resp_data;
    logic     mem_resp_valid;
`ifdef ICACHE_INVALIDATE_EN
    logic     inv_i;
    logic     inv_done;
`endif

    always #5 clk = ~clk;

    icache_responder #(.LINES(LINES)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .icache_flush_i      (flush),
        .icache_req_addr_i   (req_addr),
        .icache_req_valid_i  (req_valid),
        .icache_req_ready_o  (req_ready),
        .icache_resp_addr_o  (resp_addr),
        .icache_resp_data_o  (resp_data),
        .icache_resp_valid_o (resp_valid),
        .icache_resp_ready_i (resp_ready),
        .mem_req_addr_o      (mem_req_addr),
        .mem_req_valid_o     (mem_req_valid),
        .mem_req_ready_i     (mem_req_ready),
        .mem_resp_data_i     (mem_resp_data),
        .mem_resp_valid_i    (mem_resp_valid)
`ifdef ICACHE_INVALIDATE_EN
        ,
        .inv_i               (inv_i),
        .inv_done_o          (inv_done)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Backing memory contents: a fixed function of the address.
    function automatic word_t mem_word(input memaddr_t a);
        word_t w;
        if (a == 30'h10) w = 32'hDEADBEEF;
        else w = {2'b01, a} ^ 32'h5A5A_A5A5;
        return w;
    endfunction

    // Reference model state: owed responses, expected misses, cache contents.
    memaddr_t exp_q[$];
    memaddr_t miss_q[$];
    bit       mdl_v[LINES];
    memaddr_t mdl_a[LINES];
    int       mem_cnt  = 0;
    int       resp_cnt = 0;

    typedef struct {
        memaddr_t addr;
        int       due;
    } mreq_t;
    mreq_t mq[$];
    bit    rand_mem = 1'b0;
    int    last_due = 0;

    // Backing memory: ready policy and in-order read returns.
    always @(posedge clk) begin
        #1;
        mem_req_ready  = rand_mem ? ($urandom_range(9) < 6) : 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    end

    logic     pv = 1'b0, prdy = 1'b0, pfl = 1'b0;
    memaddr_t paddr;
    word_t    pdata;

    // Monitor: observe handshakes that will fire at the next rising edge.
    always @(negedge clk) begin
        int       idx;
        int       lat;
        int       due;
        memaddr_t a;
        if (!rst_i) begin
            if (pv && !prdy && !pfl) begin
                chk("resp_hold_valid", 64'(resp_valid), 64'(1));
                chk("resp_hold_addr", 64'(resp_addr), 64'(paddr));
                chk("resp_hold_data", 64'(resp_data), 64'(pdata));
            end
            if (resp_valid && resp_ready) begin
                resp_cnt++;
                chk("resp_owed", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    chk("resp_addr", 64'(resp_addr), 64'(a));
                    chk("resp_data", 64'(resp_data), 64'(mem_word(a)));
                end
            end
            if (flush) exp_q.delete();
            if (req_valid && req_ready) begin
                exp_q.push_back(req_addr);
                idx = int'(req_addr % LINES);
                if (!(mdl_v[idx] && mdl_a[idx] == req_addr)) begin
                    miss_q.push_back(req_addr);
                    mdl_v[idx] = 1'b1;
                    mdl_a[idx] = req_addr;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                mem_cnt++;
                chk("mem_req_owed", 64'(miss_q.size() > 0), 64'(1));
                if (miss_q.size() > 0) chk("mem_req_addr", 64'(mem_req_addr), 64'(miss_q.pop_front()));
                lat = rand_mem ? int'($urandom_range(4, 1)) : 3;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: mem_req_addr, due: due});
            end
`ifdef ICACHE_INVALIDATE_EN
            if (inv_i) foreach (mdl_v[i]) mdl_v[i] = 1'b0;
`endif
        end
        pv    = resp_valid;
        prdy  = resp_ready;
        pfl   = flush;
        paddr = resp_addr;
        pdata = resp_data;
    end

    // One request with resp_ready held high; reports response, latency and mem requests.
    task automatic do_req(input memaddr_t a, output memaddr_t ra, output word_t rd,
                          output int lat, output int nm);
        int m0;
        int t;
        m0 = mem_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("req_accept_timeout", 64'(t < 200), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_timeout", 64'(lat < 200), 64'(1));
        ra = resp_addr;
        rd = resp_data;
        nm = mem_cnt - m0;
    endtask

    typedef struct {
        memaddr_t addr;
        bit       miss;
        word_t    data;
    } vec_t;

    vec_t vt[11];

    initial begin
        memaddr_t ra;
        word_t    rd;
        int       lat, nm, t, r0;
        rst_i      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
`ifdef ICACHE_INVALIDATE_EN
        inv_i = 1'b0;
`endif

        vt[0]  = '{30'h0000010, 1'b1, 32'hDEADBEEF};
        vt[1]  = '{30'h0000010, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{30'h0000003, 1'b1, mem_word(30'h0000003)};
        vt[3]  = '{30'h0000043, 1'b1, mem_word(30'h0000043)};
        vt[4]  = '{30'h0000003, 1'b1, mem_word(30'h0000003)};
        vt[5]  = '{30'h0000043, 1'b1, mem_word(30'h0000043)};
        vt[6]  = '{30'h0000043, 1'b0, mem_word(30'h0000043)};
        vt[7]  = '{30'h3FFFFFFF, 1'b1, mem_word(30'h3FFFFFFF)};
        vt[8]  = '{30'h3FFFFFFF, 1'b0, mem_word(30'h3FFFFFFF)};
        vt[9]  = '{30'h0000000, 1'b1, mem_word(30'h0000000)};
        vt[10] = '{30'h0000000, 1'b0, mem_word(30'h0000000)};

        repeat (2) begin
            @(negedge clk);
            chk("reset_req_ready", 64'(req_ready), 64'(0));
            chk("reset_resp_valid", 64'(resp_valid), 64'(0));
            chk("reset_mem_req_valid", 64'(mem_req_valid), 64'(0));
        end
        @(posedge clk); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_req(vt[i].addr, ra, rd, lat, nm);
            chk($sformatf("vec%0d_addr", i), 64'(ra), 64'(vt[i].addr));
            chk($sformatf("vec%0d_data", i), 64'(rd), 64'(vt[i].data));
            chk($sformatf("vec%0d_mem_reqs", i), 64'(nm), 64'(vt[i].miss));
            if (!vt[i].miss) chk($sformatf("vec%0d_hit_latency", i), 64'(lat), 64'(1));
        end

        for (int i = 0; i < 8; i++) begin
            do_req(memaddr_t'(32 + i), ra, rd, lat, nm);
            chk("prefill_mem_reqs", 64'(nm), 64'(1));
        end
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 8);
            req_addr  = memaddr_t'(32 + i);
            @(negedge clk);
            if (i < 8) chk("stream_req_ready", 64'(req_ready), 64'(1));
            if (i > 0) begin
                chk("stream_resp_valid", 64'(resp_valid), 64'(1));
                chk("stream_resp_addr", 64'(resp_addr), 64'(32 + i - 1));
            end
        end

        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 30'h21;
        @(negedge clk);
        chk("bp_first_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_addr = 30'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_addr", 64'(resp_addr), 64'(30'h21));
            chk("bp_data", 64'(resp_data), 64'(mem_word(30'h21)));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        r0 = resp_cnt;
        req_valid = 1'b1;
        req_addr  = 30'h40;
        @(negedge clk);
        chk("fmiss_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(mem_req_valid && mem_req_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("fmiss_mem_req_seen", 64'(t < 50), 64'(1));
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fmiss_no_response", 64'(resp_cnt - r0), 64'(0));
        do_req(30'h40, ra, rd, lat, nm);
        chk("fmiss_refetch_mem_reqs", 64'(nm), 64'(0));
        chk("fmiss_refetch_latency", 64'(lat), 64'(1));
        chk("fmiss_refetch_data", 64'(rd), 64'(mem_word(30'h40)));

        do_req(30'h05, ra, rd, lat, nm);
        do_req(30'h80, ra, rd, lat, nm);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 30'h05;
        @(negedge clk);
        chk("fnew_first_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_addr = 30'h80;
        @(negedge clk);
        chk("fnew_pending_addr", 64'(resp_addr), 64'(30'h05));
        chk("fnew_blocked_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("fnew_flush_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("fnew_resp_valid", 64'(resp_valid), 64'(1));
        chk("fnew_resp_addr", 64'(resp_addr), 64'(30'h80));
        chk("fnew_resp_data", 64'(resp_data), 64'(mem_word(30'h80)));

`ifdef ICACHE_INVALIDATE_EN
        begin
            int bad, done;
            @(posedge clk); #1;
            inv_i = 1'b1;
            @(negedge clk);
            chk("inv_gate_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            inv_i = 1'b0;
            bad  = 0;
            done = 0;
            for (int i = 0; i < LINES; i++) begin
                @(negedge clk);
                if (req_ready) bad++;
                if (inv_done) done++;
            end
            chk("sweep_ready_low", 64'(bad), 64'(0));
            chk("sweep_done_early", 64'(done), 64'(0));
            @(negedge clk);
            chk("sweep_done_pulse", 64'(inv_done), 64'(1));
            chk("sweep_ready_back", 64'(req_ready), 64'(1));
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (inv_done) done++;
            end
            chk("sweep_done_once", 64'(done), 64'(0));
            do_req(30'h21, ra, rd, lat, nm);
            chk("sweep_refetch_mem_reqs", 64'(nm), 64'(1));
        end
`endif

        rand_mem = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            req_valid  = ($urandom_range(9) < 7);
            req_addr   = memaddr_t'($urandom_range(3) * 64 + $urandom_range(7));
            resp_ready = ($urandom_range(9) < 7);
            flush      = ($urandom_range(99) < 3);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || miss_q.size() != 0 || mq.size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("drain_exp_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_miss_empty", 64'(miss_q.size()), 64'(0));
        rand_mem = 1'b0;
        do_req(30'h1234, ra, rd, lat, nm);
        chk("final_miss_addr", 64'(ra), 64'(30'h1234));
        chk("final_miss_data", 64'(rd), 64'(mem_word(30'h1234)));
        chk("final_miss_mem_reqs", 64'(nm), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
